adder_ring_counter: RTL and testbench

Measurement back-end for the instrumented adder: consumes the free-running ring-oscillator signal produced by the adder's chain output loop and counts its rising edges over a programmable window of `wb_clk_i` cycles. The resulting count gives the ring frequency, and from it the adder's propagation delay. The block sits directly downstream of the adder inside the project wrapper. It is controlled and read back over logic-analyser bits.

---
 rtl/adder_ring_counter.sv | 134 +++++++++++++
 tb/tb_adder_ring_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_ring_counter.sv
// adder_ring_counter: counts rising edges of the adder's ring-oscillator output
// over a programmable window of wb_clk_i cycles.
// Optional build macro: ADDER_RING_COUNTER_PRESCALE_EN inserts a ring-clocked
// prescaler that divides ring_in by 2**PRESCALE_W ahead of the synchroniser.
module adder_ring_counter #(
    parameter int unsigned COUNT_W     = 32,
    parameter int unsigned WINDOW_W    = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PRESCALE_W  = 4
) (
    input  logic                wb_clk_i,
    input  logic                rst_n,
    input  logic                ring_in,
    input  logic                start,
    input  logic [WINDOW_W-1:0] window_cycles,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  count,
    output logic                overflow
);

    // ARM timer only has to reach SYNC_STAGES-1
    localparam int unsigned ARM_W = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q;
    logic [ARM_W-1:0]         arm_timer_q;
    logic [WINDOW_W-1:0]      window_q;
    logic [WINDOW_W-1:0]      win_cnt_q;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     ring_prev_q;
    logic                     ring_src;
    logic                     rise_c;

`ifdef ADDER_RING_COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0]    prescale_q;

    // Divider clocked by the ring itself; its phase is deliberately kept across starts
    always_ff @(posedge ring_in or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_q + PRESCALE_W'(1);
        end
    end

    assign ring_src = prescale_q[PRESCALE_W-1];
`else
    assign ring_src = ring_in;
`endif

    // Synchroniser plus edge-detect flop; both run continuously so ARM can flush them
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            ring_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], ring_src};
            ring_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~ring_prev_q;

    // Measurement FSM with registered status and saturating edge count
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            arm_timer_q <= '0;
            window_q    <= '0;
            win_cnt_q   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_ARM;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        count       <= '0;
                        overflow    <= 1'b0;
                        window_q    <= window_cycles;
                        arm_timer_q <= '0;
                    end
                end
                S_ARM: begin
                    if (arm_timer_q == ARM_W'(SYNC_STAGES - 1)) begin
                        win_cnt_q <= '0;
                        if (window_q != '0) begin
                            state_q <= S_COUNT;
                        end else begin
                            state_q <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        arm_timer_q <= arm_timer_q + ARM_W'(1);
                    end
                end
                S_COUNT: begin
                    if (rise_c) begin
                        if (count == '1) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + COUNT_W'(1);
                        end
                    end
                    if (win_cnt_q == window_q - WINDOW_W'(1)) begin
                        state_q <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        win_cnt_q <= win_cnt_q + WINDOW_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_ring_counter.sv
// Directed bench for adder_ring_counter: a 32-bit counter instance and a
// 4-bit counter instance for saturation share clock, reset and ring.
`timescale 1ns/1ps
module tb_adder_ring_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ring_in;
    int          ring_half = 0;

    logic        start = 1'b0;
    logic [31:0] window_cycles = '0;
    logic        busy;
    logic        done;
    logic [31:0] count;
    logic        overflow;

    logic        start_s = 1'b0;
    logic [31:0] win_s = '0;
    logic        busy_s;
    logic        done_s;
    logic [3:0]  count_s;
    logic        overflow_s;

    int errors = 0;
    int checks = 0;
    int bad;

    adder_ring_counter #(
        .COUNT_W(32), .WINDOW_W(32), .SYNC_STAGES(2), .PRESCALE_W(3)
    ) dut (
        .wb_clk_i(clk), .rst_n(rst_n), .ring_in(ring_in), .start(start),
        .window_cycles(window_cycles), .busy(busy), .done(done),
        .count(count), .overflow(overflow)
    );

    adder_ring_counter #(
        .COUNT_W(4), .WINDOW_W(32), .SYNC_STAGES(2), .PRESCALE_W(4)
    ) dut_sat (
        .wb_clk_i(clk), .rst_n(rst_n), .ring_in(ring_in), .start(start_s),
        .window_cycles(win_s), .busy(busy_s), .done(done_s),
        .count(count_s), .overflow(overflow_s)
    );

    // 10 ns clock, rising edges at 5 mod 10
    initial forever #5 clk = ~clk;

    // Ring toggles at 3 mod 10, never on a clock edge; half period in clocks
    initial begin
        ring_in = 1'b0;
        #3;
        forever begin
            if (ring_half == 0) begin
                #10;
            end else begin
                #(ring_half * 10);
                ring_in = ~ring_in;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [63:0] obs,
                               input logic [63:0] lo, input logic [63:0] hi);
        checks++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    initial begin
        // Reset held with start high and ring toggling
        ring_half     = 2;
        start         = 1'b1;
        start_s       = 1'b1;
        window_cycles = 32'd5;
        win_s         = 32'd5;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || done || overflow || count != 0 ||
                busy_s || done_s || overflow_s || count_s != 0) bad++;
        end
        check("reset_hold", 64'(bad), 64'd0);
        start   = 1'b0;
        start_s = 1'b0;
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || done || busy_s || done_s) bad++;
        end
        check("idle_after_reset", 64'(bad), 64'd0);

        // Nominal: period 8, W=80
        ring_half = 4;
        for (int i = 0; i < 10; i++) tick();
        window_cycles = 32'd80;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("nom_busy_at_N", 64'({busy, done}), 64'b10);
        bad = 0;
        for (int i = 1; i <= 81; i++) begin
            tick();
            if (!busy || done) bad++;
        end
        check("nom_busy_span", 64'(bad), 64'd0);
        tick();
        check("nom_done_at_N82", 64'({busy, done}), 64'b01);
        check_range("nom_count", 64'(count), 64'd9, 64'd11);
        check("nom_overflow", 64'(overflow), 64'd0);

        // Zero window, then a W=16 restart from DONE with period 4
        ring_half = 2;
        window_cycles = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_busy_N", 64'({busy, done}), 64'b10);
        tick();
        check("zero_busy_N1", 64'({busy, done}), 64'b10);
        tick();
        check("zero_done_N2", 64'({busy, done}), 64'b01);
        check("zero_count", 64'(count), 64'd0);
        window_cycles = 32'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done_drops", 64'({busy, done}), 64'b10);
        bad = 0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (!busy || done) bad++;
        end
        check("restart_busy_span", 64'(bad), 64'd0);
        tick();
        check("restart_done", 64'({busy, done}), 64'b01);
        check_range("restart_count", 64'(count), 64'd3, 64'd5);

        // Saturation on the 4-bit instance, start pulses during COUNT ignored
        win_s = 32'd100;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        bad = 0;
        for (int i = 1; i <= 101; i++) begin
            tick();
            if (!busy_s || done_s) bad++;
            start_s = (i == 10 || i == 50 || i == 90);
        end
        start_s = 1'b0;
        check("sat_busy_span", 64'(bad), 64'd0);
        tick();
        check("sat_done", 64'({busy_s, done_s}), 64'b01);
        check("sat_count", 64'(count_s), 64'd15);
        check("sat_overflow", 64'(overflow_s), 64'd1);

        // Reset one cycle at window cycle 20
        window_cycles = 32'd80;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 22; i++) tick();
        check("mid_busy_before_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", 64'({busy, done, overflow, count}), 64'd0);
        check("mid_rst_sat_outputs", 64'({busy_s, done_s, overflow_s, count_s}), 64'd0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy || done) bad++;
        end
        check("mid_no_done_after", 64'(bad), 64'd0);

`ifdef ADDER_RING_COUNTER_PRESCALE_EN
        // Prescaler by 8: ring period 2 clocks, W=160
        ring_half = 1;
        for (int i = 0; i < 20; i++) tick();
        window_cycles = 32'd160;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 161; i++) tick();
        tick();
        check("pre_done", 64'({busy, done}), 64'b01);
        check_range("pre_count", 64'(count), 64'd9, 64'd11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
